// File: rtl/updown_cnt_sched_pkg.sv
// Shared op encodings and FSM state type for the up/down counter command scheduler.
package updown_cnt_sched_pkg;

   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_UP     = 2'b01;
   localparam logic [1:0] OP_DOWN   = 2'b10;
   localparam logic [1:0] OP_RUN_TO = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_COUNT = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/updown_cnt_sched_if.sv
// Requester-side command handshake and completion report of the counter scheduler.
interface updown_cnt_sched_if #(
   parameter int WIDTH = 8
);
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [3:0]         req_op;
   logic [2*WIDTH-1:0] req_arg;
   logic               busy;
   logic               done;
   logic               done_id;
   logic [WIDTH-1:0]   done_q;

   modport master (
      output req_valid, req_op, req_arg,
      input  req_ready, busy, done, done_id, done_q
   );

   modport slave (
      input  req_valid, req_op, req_arg,
      output req_ready, busy, done, done_id, done_q
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   // prio_reg = 1 means requester 1 wins a tie
   logic prio_reg;

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = prio_reg ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio_reg <= 1'b0;
      end else if (accept) begin
         prio_reg <= grant[0];
      end
   end

endmodule

// File: rtl/updown_cnt_sched.sv
// Schedules LOAD / UP-N / DOWN-N / RUN-TO commands from two requesters onto one shared up/down counter.
module updown_cnt_sched
   import updown_cnt_sched_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   updown_cnt_sched_if.slave  bus,
   output logic               cnt_load,
   output logic               cnt_en,
   output logic               cnt_up,
   output logic [WIDTH-1:0]   cnt_d,
   input  logic [WIDTH-1:0]   cnt_q
);

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   steps_reg, steps_next;
   logic [WIDTH-1:0]   arg_reg, arg_next;
   logic               owner_reg, owner_next;
   logic               dir_reg, dir_next;

   logic [1:0]         op_arr  [2];
   logic [WIDTH-1:0]   arg_arr [2];
   logic [1:0]         grant;
   logic [1:0]         ready;
   logic               accept;
   logic               sel;
   logic [1:0]         sel_op;
   logic [WIDTH-1:0]   sel_arg;
   logic               dec_dir;
   logic [WIDTH-1:0]   dec_steps;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign op_arr[gi]  = bus.req_op[2*gi +: 2];
         assign arg_arr[gi] = bus.req_arg[WIDTH*gi +: WIDTH];
      end
   endgenerate

   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (bus.req_valid),
      .accept (accept),
      .grant  (grant)
   );

   assign ready         = (state_reg == ST_IDLE) ? grant : 2'b00;
   assign bus.req_ready = ready;
   assign accept        = |(bus.req_valid & ready);
   assign sel           = ready[1];
   assign sel_op        = op_arr[sel];
   assign sel_arg       = arg_arr[sel];
   assign bus.busy      = (state_reg != ST_IDLE);

   // RUN_TO takes the direct (non-wrapping) path to the target
   always_comb begin
      dec_dir   = (sel_op == OP_UP);
      dec_steps = sel_arg;
      if (sel_op == OP_RUN_TO) begin
         if (sel_arg > cnt_q) begin
            dec_dir   = 1'b1;
            dec_steps = sel_arg - cnt_q;
         end else begin
            dec_dir   = 1'b0;
            dec_steps = cnt_q - sel_arg;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      steps_next  = steps_reg;
      arg_next    = arg_reg;
      owner_next  = owner_reg;
      dir_next    = dir_reg;
      cnt_load    = 1'b0;
      cnt_en      = 1'b0;
      cnt_up      = 1'b0;
      cnt_d       = '0;
      bus.done    = 1'b0;
      bus.done_id = 1'b0;
      bus.done_q  = '0;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               owner_next = sel;
               arg_next   = sel_arg;
               if (sel_op == OP_LOAD) begin
                  dir_next   = 1'b0;
                  steps_next = '0;
                  state_next = ST_LOAD;
               end else begin
                  dir_next   = dec_dir;
                  steps_next = dec_steps;
                  state_next = (dec_steps == '0) ? ST_DONE : ST_COUNT;
               end
            end
         end
         ST_LOAD: begin
            cnt_load   = 1'b1;
            cnt_d      = arg_reg;
            state_next = ST_DONE;
         end
         ST_COUNT: begin
            cnt_en     = 1'b1;
            cnt_up     = dir_reg;
            steps_next = steps_reg - 1'b1;
            if (steps_reg == WIDTH'(1)) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            bus.done    = 1'b1;
            bus.done_id = owner_reg;
            bus.done_q  = cnt_q;
            state_next  = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         steps_reg <= '0;
         arg_reg   <= '0;
         owner_reg <= 1'b0;
         dir_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         steps_reg <= steps_next;
         arg_reg   <= arg_next;
         owner_reg <= owner_next;
         dir_reg   <= dir_next;
      end
   end

endmodule

// File: doc/updown_cnt_sched.md
Name: updown_cnt_sched

Overview:
Command scheduler that shares one external 8-bit bidirectional counter (load/en/up_downb/d/q interface) between two requesters. It accepts LOAD, COUNT-UP-N, COUNT-DOWN-N and RUN-TO-TARGET commands over a valid/ready handshake and arbitrates round-robin. It sequences the counter's control pins cycle by cycle and reports completion with the final count. It sits between the counter and the control logic of the blocks that share it.

Parameters:
WIDTH, 8, counter width; also the width of cnt_d, cnt_q, req_arg, done_q and the internal step counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  2  per-requester command valid; bit i = requester i
req_ready  out  2  per-requester accept; one-hot or zero
req_op  in  4  2 bits per requester, [2i+1:2i]; 00 LOAD, 01 UP, 10 DOWN, 11 RUN_TO
req_arg  in  2*WIDTH  per requester, [WIDTH*(i+1)-1:WIDTH*i]; load value, step count, or target
cnt_load  out  1  to counter load
cnt_en  out  1  to counter en
cnt_up  out  1  to counter up_downb (1 = up)
cnt_d  out  WIDTH  to counter d
cnt_q  in  WIDTH  counter q, registered, one-cycle update
busy  out  1  high in any state except IDLE
done  out  1  one-cycle completion pulse
done_id  out  1  requester that owned the completed command
done_q  out  WIDTH  cnt_q sampled in the DONE cycle

Behaviour:
- Reset (synchronous): state IDLE. All outputs 0. RR pointer favours requester 0. Step counter, owner and dir cleared. Reset mid-command abandons it with no done pulse.
- States: IDLE, LOAD, COUNT, DONE.
- IDLE arbitration: req_ready[i] = (state==IDLE) & grant[i], combinational from req_valid and the RR pointer.
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - RR pointer updates only on an accept.
- Accept = req_valid[i] & req_ready[i]. Latch owner, op, arg, and cnt_q at the accept edge.
- Valid must hold until accepted. Op and arg must be stable while valid. A dropped valid is not queued.
- Decode at accept:
  - LOAD -> LOAD.
  - UP/DOWN: steps = arg, dir = op==UP.
  - RUN_TO: dir = arg > cnt_q, steps = |arg - cnt_q| (unsigned, WIDTH bits).
  - steps==0 -> DONE directly; else -> COUNT.
- LOAD state, one cycle: cnt_load=1, cnt_d=arg. Next state DONE.
- COUNT state: cnt_en=1, cnt_up=dir, steps decrements each cycle. Exit to DONE on the cycle steps==1. Exactly N cycles with en high.
- DONE state, one cycle: done=1, done_id=owner, done_q=cnt_q. Next state IDLE; no accept in DONE.
- Outside LOAD/COUNT: cnt_load=0, cnt_en=0, cnt_up=0, cnt_d=0. cnt_load and cnt_en are never high together.
- Latency from the accept edge at cycle T:
  - LOAD: done at T+2.
  - N-step count: done at T+N+1.
  - Zero-step: done at T+1.
  - Next accept possible at the cycle after DONE.
- Wrap-around is modulo 2^WIDTH, inherent to the counter; the scheduler does no saturation. RUN_TO never wraps because it takes the direct path.
- Max N = 2^WIDTH-1; the step counter is WIDTH bits.

Decomposition:
- Package updown_cnt_sched_pkg:
  - op encoding constants OP_LOAD=2'b00, OP_UP=2'b01, OP_DOWN=2'b10, OP_RUN_TO=2'b11;
  - state typedef (IDLE, LOAD, COUNT, DONE).
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - inputs: clk, reset, req[1:0], accept;
  - output: grant[1:0], one-hot or zero;
  - pointer advances on accept.
- Bench instantiates the existing 8-bit bidirectional counter on the cnt_* pins. Its reset is tied to the scheduler reset.

Test Plan:
- Req0 LOAD 0x5A, single requester -> cnt_load=1, cnt_d=0x5A one cycle; done at T+2, done_id=0, done_q=0x5A.
- Counter at 0xFE, req1 UP 3 -> cnt_en high exactly 3 cycles with cnt_up=1; done_q=0x01, done_id=1.
- Counter at 0x10, RUN_TO 0x0C -> 4 down cycles, done_q=0x0C. Repeat with RUN_TO 0x10 -> no en cycles, done at T+1, done_q=0x10.
- Both requesters valid continuously with UP 1 -> grants alternate 0,1,0,1. req_ready is never high during LOAD, COUNT or DONE, and never both bits high.
- DOWN 0 -> done at T+1 with cnt_en never asserted.
- Reset asserted mid-COUNT (DOWN 10, after 4 steps) -> next cycle IDLE, all outputs 0, no done. RR favours requester 0 on the next simultaneous request.
